// File: rtl/interrupt_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_dispatch
// Description : CPU-side end of the interrupt path. Latches the winning
//               request from the priority encoder, presents it to the core
//               with a req/ack handshake, pulses a one-hot clear back to the
//               source on ack and tracks the in-service source until EOI.
//               No preemption; every output is registered.
// Ports       : clk, rst          - clock (rising edge), sync active-high reset
//               irq_valid, irq_id - request from priority encoder
//               cpu_irq, cpu_id   - request / latched ID to the core
//               cpu_ack, cpu_eoi  - core accepts / core finished handler
//               irq_clear         - one-hot, single-cycle clear to the source
//               in_service        - one-hot, source currently being serviced
//               busy              - high whenever a request is outstanding
//               done_cnt          - completed services, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_dispatch #(
  parameter int NUM_IRQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               irq_valid,
  input  logic [ID_W-1:0]    irq_id,
  output logic               cpu_irq,
  output logic [ID_W-1:0]    cpu_id,
  input  logic               cpu_ack,
  input  logic               cpu_eoi,
  output logic [NUM_IRQ-1:0] irq_clear,
  output logic [NUM_IRQ-1:0] in_service,
  output logic               busy,
  output logic [CNT_W-1:0]   done_cnt
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_SERVICE = 2'd2
  } state_t;

  // One extra bit so NUM_IRQ == 2**ID_W is representable.
  localparam logic [ID_W:0] ID_LIMIT = (ID_W+1)'(NUM_IRQ);

  state_t               state_q, state_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic                 cpu_irq_q, cpu_irq_d;
  logic [ID_W-1:0]      cpu_id_q, cpu_id_d;
  logic [NUM_IRQ-1:0]   irq_clear_q, irq_clear_d;
  logic [NUM_IRQ-1:0]   in_service_q, in_service_d;
  logic                 busy_q, busy_d;
  logic [CNT_W-1:0]     done_cnt_q, done_cnt_d;

  logic                 id_in_range;
  logic [NUM_IRQ-1:0]   id_onehot;

  assign id_in_range = ({1'b0, irq_id} < ID_LIMIT);
  assign id_onehot   = NUM_IRQ'(1) << id_q;

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    cpu_irq_d    = cpu_irq_q;
    cpu_id_d     = cpu_id_q;
    irq_clear_d  = '0;            // clear is only ever a one-cycle pulse
    in_service_d = in_service_q;
    done_cnt_d   = done_cnt_q;

    unique case (state_q)
      S_IDLE: begin
        // Out-of-range IDs are silently dropped; ack/eoi have no meaning here.
        if (irq_valid && id_in_range) begin
          id_d      = irq_id;
          cpu_id_d  = irq_id;
          cpu_irq_d = 1'b1;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        // Encoder changes are ignored; an eoi on the ack edge is discarded.
        if (cpu_ack) begin
          cpu_irq_d    = 1'b0;
          irq_clear_d  = id_onehot;
          in_service_d = id_onehot;
          state_d      = S_SERVICE;
        end
      end
      S_SERVICE: begin
        if (cpu_eoi) begin
          in_service_d = '0;
          if (done_cnt_q != {CNT_W{1'b1}}) begin
            done_cnt_d = done_cnt_q + 1'b1;
          end
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      id_q         <= '0;
      cpu_irq_q    <= 1'b0;
      cpu_id_q     <= '0;
      irq_clear_q  <= '0;
      in_service_q <= '0;
      busy_q       <= 1'b0;
      done_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      cpu_irq_q    <= cpu_irq_d;
      cpu_id_q     <= cpu_id_d;
      irq_clear_q  <= irq_clear_d;
      in_service_q <= in_service_d;
      busy_q       <= busy_d;
      done_cnt_q   <= done_cnt_d;
    end
  end

  assign cpu_irq    = cpu_irq_q;
  assign cpu_id     = cpu_id_q;
  assign irq_clear  = irq_clear_q;
  assign in_service = in_service_q;
  assign busy       = busy_q;
  assign done_cnt   = done_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_interrupt_dispatch
// Description : Self-checking bench for interrupt_dispatch. A fixed vector
//               table covers reset, the basic handshake, ignored encoder
//               changes, ack+eoi collision and reset mid-service; a
//               hand-written loop covers counter saturation; random traffic
//               is checked against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_dispatch;

  localparam int NUM_IRQ = 4;
  localparam int ID_W    = 2;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst;
  logic               irq_valid;
  logic [ID_W-1:0]    irq_id;
  logic               cpu_irq;
  logic [ID_W-1:0]    cpu_id;
  logic               cpu_ack;
  logic               cpu_eoi;
  logic [NUM_IRQ-1:0] irq_clear;
  logic [NUM_IRQ-1:0] in_service;
  logic               busy;
  logic [CNT_W-1:0]   done_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  interrupt_dispatch #(.NUM_IRQ(NUM_IRQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_valid  (irq_valid),
    .irq_id     (irq_id),
    .cpu_irq    (cpu_irq),
    .cpu_id     (cpu_id),
    .cpu_ack    (cpu_ack),
    .cpu_eoi    (cpu_eoi),
    .irq_clear  (irq_clear),
    .in_service (in_service),
    .busy       (busy),
    .done_cnt   (done_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (transaction view) ----------------
  // A source is either waiting for the core to take it, being handled,
  // or there is nothing outstanding.
  bit          m_waiting;
  bit          m_handling;
  int          m_src;
  int          m_shown_id;
  int          m_clear;
  int          m_done;

  function automatic int onehot(input int src);
    return 1 << src;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_waiting = 0; m_handling = 0; m_src = 0; m_shown_id = 0;
      m_clear = 0; m_done = 0;
    end else begin
      m_clear = 0;
      if (m_waiting) begin
        if (cpu_ack) begin
          m_waiting  = 0;
          m_handling = 1;
          m_clear    = onehot(m_src);
        end
      end else if (m_handling) begin
        if (cpu_eoi) begin
          m_handling = 0;
          m_done     = (m_done < CNT_MAX) ? m_done + 1 : CNT_MAX;
        end
      end else if (irq_valid && int'(irq_id) < NUM_IRQ) begin
        m_waiting  = 1;
        m_src      = int'(irq_id);
        m_shown_id = m_src;
      end
    end
  endtask

  function automatic logic [19:0] pack_exp(input bit irq, input int id, input int clr,
                                           input int svc, input bit bsy, input int cnt);
    return {irq, ID_W'(id), NUM_IRQ'(clr), NUM_IRQ'(svc), bsy, CNT_W'(cnt)};
  endfunction

  function automatic logic [19:0] model_out();
    return pack_exp(m_waiting, m_shown_id, m_clear,
                    m_handling ? onehot(m_src) : 0,
                    m_waiting || m_handling, m_done);
  endfunction

  function automatic logic [19:0] dut_out();
    return {cpu_irq, cpu_id, irq_clear, in_service, busy, done_cnt};
  endfunction

  // One rising edge: model follows the same sampled inputs, outputs are
  // then read 1 time unit later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {irq,id,clr,svc,busy,cnt}=%05h expected %05h", name, act, exp);
    end
  endtask

  task automatic drive(input bit r, input bit v, input int id, input bit a, input bit e);
    rst = r; irq_valid = v; irq_id = ID_W'(id); cpu_ack = a; cpu_eoi = e;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit r; bit v; int id; bit a; bit e;
    bit x_irq; int x_id; int x_clr; int x_svc; bit x_busy; int x_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit r, input bit v, input int id, input bit a, input bit e,
                     input bit xi, input int xid, input int xc, input int xs,
                     input bit xb, input int xn);
    vec_t t;
    t.r = r; t.v = v; t.id = id; t.a = a; t.e = e;
    t.x_irq = xi; t.x_id = xid; t.x_clr = xc; t.x_svc = xs; t.x_busy = xb; t.x_cnt = xn;
    tbl.push_back(t);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0);

    //   r v id a e   irq id clr     svc     busy cnt
    // reset with busy inputs
    add(1, 1, 3, 1, 1,  0, 0, 0,      0,      0, 0);
    add(1, 1, 1, 0, 1,  0, 0, 0,      0,      0, 0);
    // basic service of source 2
    add(0, 1, 2, 0, 0,  1, 2, 0,      0,      1, 0);
    add(0, 0, 0, 1, 0,  0, 2, 4'b0100, 4'b0100, 1, 0);
    add(0, 0, 0, 0, 0,  0, 2, 0,      4'b0100, 1, 0);
    add(0, 0, 0, 0, 0,  0, 2, 0,      4'b0100, 1, 0);
    add(0, 0, 0, 0, 1,  0, 2, 0,      0,      0, 1);
    // encoder changes ignored while waiting for ack
    add(0, 1, 2, 0, 0,  1, 2, 0,      0,      1, 1);
    add(0, 1, 0, 0, 0,  1, 2, 0,      0,      1, 1);
    add(0, 0, 0, 1, 0,  0, 2, 4'b0100, 4'b0100, 1, 1);
    add(0, 0, 0, 0, 1,  0, 2, 0,      0,      0, 2);
    // ack+eoi on the same edge: eoi dropped
    add(0, 1, 1, 0, 0,  1, 1, 0,      0,      1, 2);
    add(0, 0, 0, 1, 1,  0, 1, 4'b0010, 4'b0010, 1, 2);
    // eoi with a request already present: one idle cycle before it is taken
    add(0, 1, 3, 0, 1,  0, 1, 0,      0,      0, 3);
    add(0, 1, 3, 0, 0,  1, 3, 0,      0,      1, 3);
    add(0, 0, 0, 1, 0,  0, 3, 4'b1000, 4'b1000, 1, 3);
    // reset mid-service, then stray ack/eoi in idle
    add(1, 0, 0, 0, 0,  0, 0, 0,      0,      0, 0);
    add(0, 0, 0, 1, 1,  0, 0, 0,      0,      0, 0);
    // reset on the ack edge: no clear pulse
    add(0, 1, 3, 0, 0,  1, 3, 0,      0,      1, 0);
    add(1, 0, 0, 1, 0,  0, 0, 0,      0,      0, 0);
    add(0, 0, 0, 0, 0,  0, 0, 0,      0,      0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].v, tbl[i].id, tbl[i].a, tbl[i].e);
      tick();
      check($sformatf("vec%0d", i), dut_out(),
            pack_exp(tbl[i].x_irq, tbl[i].x_id, tbl[i].x_clr, tbl[i].x_svc,
                     tbl[i].x_busy, tbl[i].x_cnt));
    end

    // ---------------- saturation run: 260 services ----------------
    drive(1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 260; i++) begin
      drive(0, 1, i % 4, 0, 0);
      tick();
      check("sat_req", dut_out(), model_out());
      drive(0, 0, 0, 1, 0);
      tick();
      check("sat_clear", {16'd0, irq_clear}, {16'd0, NUM_IRQ'(onehot(i % 4))});
      drive(0, 0, 0, 0, 1);
      tick();
      check("sat_eoi", dut_out(), model_out());
      drive(0, 0, 0, 0, 0);
      tick();
    end
    check("sat_final", {12'd0, done_cnt}, {12'd0, CNT_W'(CNT_MAX)});

    // ---------------- random traffic vs model ----------------
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 63) == 0), $urandom_range(0, 1), $urandom_range(0, 3),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
      tick();
      check("random", dut_out(), model_out());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
